// File: rtl/rsa_modexp_sched_if.sv
// Multiplier-side bus of the modexp sequencer: one start/done transaction
// carrying two operands out and one product back.
interface rsa_modexp_sched_if #(
    parameter int W = 1024
);
    logic         mm_start;
    logic [W-1:0] mm_a;
    logic [W-1:0] mm_b;
    logic         mm_done;
    logic [W-1:0] mm_p;

    modport master (output mm_start, mm_a, mm_b, input mm_done, mm_p);
    modport slave  (input mm_start, mm_a, mm_b, output mm_done, mm_p);
endinterface

// File: rtl/rsa_modexp_sched.sv
// Left-to-right square-and-multiply sequencer: schedules every squaring and
// multiply of base^exp mod N onto one shared external modular multiplier.
module rsa_modexp_sched #(
    parameter int W = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m_rst,
    input  logic                  start,
    input  logic [W-1:0]          base,
    input  logic [W-1:0]          exp,
    output logic                  busy,
    output logic                  done,
    output logic [W-1:0]          result,
    output logic [2:0]            state_dbg,
    rsa_modexp_sched_if.master    mm
);
    localparam int IDX_W = $clog2(W);

    typedef enum logic [2:0] {
        IDLE, SCAN, SQR, SQR_W, MUL, MUL_W, NEXT, FIN
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       base_q, base_d;
    logic [W-1:0]       exp_q, exp_d;
    logic [W-1:0]       acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               mm_start_q;
    logic [W-1:0]       mm_a_q, mm_b_q;

    // Handshakes: start is taken only in IDLE (never queued); mm_start is a
    // one-cycle request whose operands hold until mm_done, a one-cycle
    // completion honoured only in SQR_W/MUL_W; done pulses once per result.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        exp_d   = exp_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base;
                    exp_d   = exp;
                    idx_d   = IDX_W'(W - 1);
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (exp_q[idx_q]) begin
                    acc_d = base_q;
                    if (idx_q == '0) begin
                        state_d = FIN;
                    end else begin
                        idx_d   = idx_q - IDX_W'(1);
                        state_d = SQR;
                    end
                end else if (idx_q == '0) begin
                    acc_d   = {{(W-1){1'b0}}, 1'b1};
                    state_d = FIN;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            SQR: state_d = SQR_W;
            SQR_W: begin
                if (mm.mm_done) begin
                    acc_d   = mm.mm_p;
                    state_d = exp_q[idx_q] ? MUL : NEXT;
                end
            end
            MUL: state_d = MUL_W;
            MUL_W: begin
                if (mm.mm_done) begin
                    acc_d   = mm.mm_p;
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (idx_q == '0) begin
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q - IDX_W'(1);
                    state_d = SQR;
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (m_rst) state_d = IDLE;
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            exp_q      <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            mm_start_q <= 1'b0;
            mm_a_q     <= '0;
            mm_b_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            exp_q      <= exp_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            busy       <= (state_d != IDLE);
            done       <= (state_d == FIN);
            mm_start_q <= (state_d == SQR) || (state_d == MUL);
            if (state_d == FIN) result <= acc_d;
            if (state_d == SQR) begin
                mm_a_q <= acc_d;
                mm_b_q <= acc_d;
            end else if (state_d == MUL) begin
                mm_a_q <= acc_d;
                mm_b_q <= base_q;
            end
        end
    end

    assign mm.mm_start = mm_start_q;
    assign mm.mm_a     = mm_a_q;
    assign mm.mm_b     = mm_b_q;
    assign state_dbg   = state_q;
endmodule
